// File: rtl/uart_pkg.sv
// Shared UART definitions: frame bit constants, message-sender FSM states
// and the baud divisor helper used to size serializer counters.
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } msg_state_t;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer with a ready/valid input handshake; each bit lasts BAUD_DIV
// clock cycles and tx idles high.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int              CW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]   BAUD_LAST  = CW'(BAUD_DIV - 1);
    localparam int              FRAME_BITS = DATA_BITS + 2;
    localparam logic [3:0]      LAST_BIT   = 4'(FRAME_BITS - 1);

    logic                 active;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS:0]   shift_reg;

    assign tx_ready = !active;

    // bit_cnt numbers the bit currently on the line: 0 = start, 9 = stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            tx        <= STOP_BIT;
        end else if (!active) begin
            if (tx_valid) begin
                active    <= 1'b1;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                shift_reg <= {STOP_BIT, tx_data};
                tx        <= START_BIT;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
                active <= 1'b0;
                tx     <= STOP_BIT;
            end else begin
                bit_cnt   <= bit_cnt + 4'd1;
                tx        <= shift_reg[0];
                shift_reg <= {STOP_BIT, shift_reg[DATA_BITS:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_msg_sender.sv
// Buffered UART message transmitter: sends msg_len stored characters as 8N1
// frames separated by GAP_CYCLES idle cycles, once or repeating until stop.
module uart_msg_sender
    import uart_pkg::*;
#(
    parameter  int CLK_FREQ   = 100_000_000,
    parameter  int BAUD       = 115200,
    parameter  int DEPTH      = 16,
    parameter  int GAP_CYCLES = 10_000_000,
    parameter  int REPEAT     = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          stop,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] char_idx
);

    localparam int          BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int          GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int          GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    msg_state_t    state, state_next;
    logic [AW:0]   len;
    logic [AW-1:0] idx;
    logic [GW-1:0] gap_cnt;
    logic          stop_flag;
    logic          tx_valid, tx_ready;
    logic [7:0]    tx_data;
    logic          stop_seen, last_char, accept_start, advance, finish_done;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign tx_valid = (state == ST_LOAD);
    assign tx_data  = mem[idx];
    assign busy     = (state != ST_IDLE);
    assign char_idx = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A stop arriving in the same cycle the frame ends counts as seen.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        advance      = 1'b0;
        finish_done  = 1'b0;
        stop_seen    = stop_flag | stop;
        last_char    = ({1'b0, idx} == len - (AW + 1)'(1));
        case (state)
            ST_IDLE: begin
                if (start && msg_len != '0) begin
                    accept_start = 1'b1;
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: begin
                if (tx_ready) begin
                    if (stop_seen) begin
                        state_next = ST_IDLE;
                    end else if (last_char && REPEAT == 0) begin
                        finish_done = 1'b1;
                        state_next  = ST_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        advance    = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop_seen) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt == GW'(GAP_LAST)) begin
                    advance    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            stop_flag <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish_done;
            if (accept_start) begin
                len <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                idx <= '0;
            end else if (advance) begin
                idx <= last_char ? '0 : idx + AW'(1);
            end
            if (state == ST_GAP && state_next == ST_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (state_next == ST_IDLE) begin
                stop_flag <= 1'b0;
            end else if (state != ST_IDLE && stop) begin
                stop_flag <= 1'b1;
            end
        end
    end

    uart_tx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx_core (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx)
    );

endmodule

// File: doc/uart_msg_sender.md
# uart_msg_sender

Parametrised UART message transmitter: holds up to DEPTH characters in a host-writable buffer and, on a start pulse, serialises `msg_len` of them as 8N1 frames with a programmable idle gap between characters. It supports one-shot or continuous-repeat mode. It contains its own baud-rate serializer with a ready/valid handshake. It sits between board-level control logic (buttons, ID/text loader) and the `tx` pin.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; BAUD_DIV = CLK_FREQ/BAUD (integer, truncated), must be ≥ 2
- DEPTH, 16, buffer depth in characters; AW = clog2(DEPTH)
- GAP_CYCLES, 10_000_000, idle clk cycles between the end of one stop bit and the next start bit; 0 allowed
- REPEAT, 0, 0 = one-shot, 1 = wrap to char 0 after the last char and continue until `stop`

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous and active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_data  in  8  character to store
- msg_len  in  AW+1  characters to send; latched at start; values > DEPTH are clamped to DEPTH
- start  in  1  begin message (level sampled each cycle)
- stop  in  1  request halt after the current frame
- tx  out  1  serial line, idle high
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse when a one-shot message completes
- char_idx  out  AW  index of the character currently being sent or waited on

## Operation
- Reset values: tx=1, busy=0, done=0, char_idx=0, FSM=IDLE, serializer idle. Buffer contents are not reset.
- Writes are accepted every cycle regardless of state. A character is read at LOAD time, so a write to a not-yet-sent index takes effect.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: start=1 and msg_len≠0 → latch len, idx=0, go to LOAD. start with msg_len=0 is ignored. start while busy is ignored.
  - LOAD: present buf[idx] on tx_valid/tx_data → SEND.
  - SEND: wait for the serializer to return to ready (frame complete).
    - If stop was seen → IDLE, no done pulse.
    - Else if idx = len−1 and REPEAT=0 → done=1 for one cycle, IDLE.
    - Else → GAP.
  - GAP: count GAP_CYCLES, then go to LOAD with idx+1, or idx=0 after the last char in REPEAT mode.
    - stop seen during GAP → IDLE immediately, no further frames.
    - GAP_CYCLES=0 → GAP lasts 0 cycles; go directly from SEND to LOAD.
- stop is sticky: it is captured whenever busy and cleared on entering IDLE. A frame in flight is never truncated.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is BAUD_DIV cycles. A frame occupies exactly 10·BAUD_DIV cycles.

## Timing
- Start sampled at cycle 0 → busy=1 at cycle 1 (LOAD) → serializer accepts at cycle 2 → tx=0 from cycle 2.
- Serializer handshake: transfer occurs when tx_valid && tx_ready. tx_ready falls the cycle after acceptance and rises again the cycle after the last stop-bit cycle.
- Character spacing, start bit to start bit: 10·BAUD_DIV + GAP_CYCLES + 2 cycles (LOAD plus handshake).
- done asserts on the same cycle busy falls.
- Asynchronous reset mid-frame: tx returns to 1 immediately. No partial frame resumes after reset release.

## Structure
- Shared package/include `uart_pkg`:
  - frame constants: start, stop, and data-bit count
  - FSM state encodings
  - BAUD_DIV computation function
- Sub-module `uart_tx_core`:
  - ports: clk, rst, tx_valid, tx_data[7:0], tx_ready, tx
  - contents: baud counter, bit counter, shift register
  - reused by later UART blocks
- Top holds the buffer (distributed RAM array, no reset), the FSM, the gap counter, the length/index registers and the stop flag.

## Test plan
Bench parameters: CLK_FREQ=1000, BAUD=250 (BAUD_DIV=4), DEPTH=16, GAP_CYCLES=8.
- Basic one-shot: write "2023" to 0..3, msg_len=4, pulse start → four frames 0x32,0x30,0x32,0x33, each 40 cycles, LSB first; start-bit edges 50 cycles apart; exactly one done pulse; busy low afterwards.
- Repeat mode (REPEAT=1, len=2 "AB") → sequence 0x41,0x42,0x41,… Assert stop mid-frame of the third char → that frame completes fully, then IDLE, no done, tx stays 1.
- Edge lengths:
  - msg_len=0 with start → no activity, busy stays 0.
  - msg_len=20 → exactly 16 frames, char_idx reaches 15.
- Start while busy → ignored; the message is unchanged.
- Live buffer update: write buf[3]=0x5A while char 1 is in SEND → fourth frame carries 0x5A.
- Reset mid-frame → tx=1, busy=0, char_idx=0 immediately. A fresh start afterwards sends from index 0 with the buffer intact.
